// File: rtl/inv_shift_sub_key_stage_if.sv
// Handshake bundle for inv_shift_sub_key_stage: input state/key side and result side.
// The controller drives through master; the stage itself uses slave.
interface inv_shift_sub_key_stage_if;
    logic         InValid;
    logic         InReady;
    logic [127:0] InState;
    logic [127:0] RoundKey;
    logic         OutValid;
    logic         OutReady;
    logic [127:0] OutState;

    modport master (
        output InValid, InState, RoundKey, OutReady,
        input  InReady, OutValid, OutState
    );

    modport slave (
        input  InValid, InState, RoundKey, OutReady,
        output InReady, OutValid, OutState
    );
endinterface

// File: rtl/inv_shift_sub_key_stage.sv
// AES decryption round front-end: InvShiftRows -> InvSubBytes -> AddRoundKey, one column per cycle.
// Define INV_SHIFT_SUB_FULL_PAR_EN to substitute all 16 bytes in a single SUB cycle.
module inv_shift_sub_key_stage #(
    parameter int ADD_KEY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    inv_shift_sub_key_stage_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_out_valid;
    logic [127:0]   r_work;
    logic [127:0]   r_key;
    logic [127:0]   w_key_eff;
    logic [127:0]   w_work_next;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            else      p = p;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and naturally maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_sbox_col(input logic [31:0] col);
        logic [31:0] o;
        for (int b = 0; b < 4; b++) begin
            o[31-8*b -: 8] = inv_sbox(col[31-8*b -: 8]);
        end
        return o;
    endfunction

    // Row r of output column c comes from input column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-32*c-8*r -: 8] = s[127-32*((c-r+4)%4)-8*r -: 8];
            end
        end
        return o;
    endfunction

    assign w_key_eff = (ADD_KEY != 0) ? r_key : 128'h0;

`ifdef INV_SHIFT_SUB_FULL_PAR_EN
    // Whole-state substitution and key add in one pass.
    always_comb begin
        w_work_next = r_work;
        for (int c = 0; c < 4; c++) begin
            w_work_next[127-32*c -: 32] = inv_sbox_col(r_work[127-32*c -: 32]) ^ w_key_eff[127-32*c -: 32];
        end
    end
`else
    logic [1:0]     r_cnt;
    logic [31:0]    w_col_in;
    logic [31:0]    w_key_col;
    logic [31:0]    w_col_out;

    // Select the column addressed by the counter.
    always_comb begin
        case (r_cnt)
            2'd0:    begin w_col_in = r_work[127:96]; w_key_col = w_key_eff[127:96]; end
            2'd1:    begin w_col_in = r_work[95:64];  w_key_col = w_key_eff[95:64];  end
            2'd2:    begin w_col_in = r_work[63:32];  w_key_col = w_key_eff[63:32];  end
            2'd3:    begin w_col_in = r_work[31:0];   w_key_col = w_key_eff[31:0];   end
            default: begin w_col_in = 32'h0;          w_key_col = 32'h0;             end
        endcase
        w_col_out = inv_sbox_col(w_col_in) ^ w_key_col;
    end

    // Write the processed column back into its slot.
    always_comb begin
        w_work_next = r_work;
        case (r_cnt)
            2'd0:    w_work_next[127:96] = w_col_out;
            2'd1:    w_work_next[95:64]  = w_col_out;
            2'd2:    w_work_next[63:32]  = w_col_out;
            2'd3:    w_work_next[31:0]   = w_col_out;
            default: w_work_next         = r_work;
        endcase
    end
`endif

    // Control FSM with registered result and valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_work      <= 128'h0;
            r_key       <= 128'h0;
`ifndef INV_SHIFT_SUB_FULL_PAR_EN
            r_cnt       <= 2'd0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.InValid) begin
                        r_work  <= inv_shift_rows(bus.InState);
                        r_key   <= bus.RoundKey;
                        r_state <= SUB;
`ifndef INV_SHIFT_SUB_FULL_PAR_EN
                        r_cnt   <= 2'd0;
`endif
                    end
                end
                SUB: begin
                    r_work <= w_work_next;
`ifdef INV_SHIFT_SUB_FULL_PAR_EN
                    r_state     <= HOLD;
                    r_out_valid <= 1'b1;
`else
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_state     <= HOLD;
                        r_out_valid <= 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (bus.OutReady) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InReady  = (r_state == IDLE);
    assign bus.OutValid = r_out_valid;
    assign bus.OutState = r_work;

endmodule
